// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60Hz VGA: pixel-rate strobe, h/v counters,
// visible-area flag, sync pins and line/frame strobes for game logic.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  // Sync window bounds are 11 bits so an end bound equal to 1024 still compares correctly.
  localparam logic [10:0]      H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0]      V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0]      HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0]      HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0]      VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0]      VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             bright_q, bright_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;
  logic [10:0]      h_ext, v_ext;

  always_comb begin
    div_d        = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    pix_en_d     = (div_q == DIV_LAST);
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;

    // pix_en marks the last clk of a pixel; the counters step on the edge that ends it.
    if (pix_en_q) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d      = '0;
        line_tick_d = 1'b1;
        vcnt_d      = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        frame_tick_d = ({1'b0, vcnt_d} == V_VIS);
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end

    // Decoded from the next-state counters so they line up with hCount/vCount.
    h_ext    = {1'b0, hcnt_d};
    v_ext    = {1'b0, vcnt_d};
    bright_d = (h_ext < H_VIS) && (v_ext < V_VIS);
    hsync_d  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      pix_en_q     <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      bright_q     <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      pix_en_q     <= pix_en_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      bright_q     <= bright_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pix_en     = pix_en_q;
  assign hCount     = hcnt_q;
  assign vCount     = vcnt_q;
  assign bright     = bright_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule
